mdu_ctrl: RTL and testbench

Iterative multiply/divide sequencer for the MIPS core. It implements MULT, MULTU, DIV and DIVU by driving the shared 32-bit ALU for one add or subtract step per cycle: shift-add for multiply, restoring division for divide. Results land in internal HI/LO registers. The block sits beside the decoder. When the ALU is not needed by the main datapath, the issue logic hands it to this block; `busy` tells the issue logic to keep the ALU mux pointed here.

---
 rtl/mdu_ctrl.sv | 152 +++++++++++++++
 tb/tb_mdu_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer that borrows the shared 32-bit ALU
// for one shift-add or restoring-subtract step per cycle; results land in hi/lo.
module mdu_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [5:0]  alu_cont,
    input  logic [31:0] alu_result,
    input  logic        alu_carry,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    // state  | meaning
    // S_IDLE | waiting for start; hi/lo hold the last result
    // S_RUN  | 32 ALU steps; hi/lo double as rem/quo for divides
    // S_FIX  | sign correction and divide-by-zero override, no ALU use
    // S_DONE | done pulse, result final
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

    localparam logic [5:0] ALU_ADD = 6'b000010;
    localparam logic [5:0] ALU_SUB = 6'b100010;

    state_t      state;
    logic [5:0]  count;
    logic [1:0]  op_q;
    logic        sa;
    logic        sb;
    logic [31:0] mcand;
    logic [31:0] a_orig;
    logic        b_zero;

    logic        signed_op;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] p;
    logic        ge;
    logic [63:0] prod_neg;

    assign signed_op = ~op[0];
    assign mag_a     = (signed_op && a[31]) ? (~a + 32'd1) : a;
    assign mag_b     = (signed_op && b[31]) ? (~b + 32'd1) : b;

    // Partial remainder is 33 bits wide: {hi[31], p}.
    assign p         = {hi[30:0], lo[31]};
    assign ge        = hi[31] | alu_carry;
    assign prod_neg  = ~{hi, lo} + 64'd1;

    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_cont = ALU_ADD;
        if (state == S_RUN) begin
            if (op_q[1]) begin
                alu_a    = p;
                alu_b    = mcand;
                alu_cont = ALU_SUB;
            end else begin
                alu_a    = hi;
                alu_b    = lo[0] ? mcand : 32'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            count  <= '0;
            op_q   <= '0;
            sa     <= 1'b0;
            sb     <= 1'b0;
            mcand  <= '0;
            a_orig <= '0;
            b_zero <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state  <= S_RUN;
                        busy   <= 1'b1;
                        count  <= 6'd32;
                        op_q   <= op;
                        sa     <= signed_op & a[31];
                        sb     <= signed_op & b[31];
                        a_orig <= a;
                        b_zero <= (b == 32'd0);
                        hi     <= '0;
                        if (op[1]) begin
                            lo    <= mag_a;
                            mcand <= mag_b;
                        end else begin
                            lo    <= mag_b;
                            mcand <= mag_a;
                        end
                    end
                end
                S_RUN: begin
                    count <= count - 6'd1;
                    if (op_q[1]) begin
                        hi <= ge ? alu_result : p;
                        lo <= {lo[30:0], ge};
                    end else begin
                        {hi, lo} <= {alu_carry, alu_result, lo[31:1]};
                    end
                    if (count == 6'd1)
                        state <= S_FIX;
                end
                S_FIX: begin
                    if (op_q[1]) begin
                        if (b_zero) begin
                            lo <= 32'hFFFF_FFFF;
                            hi <= a_orig;
                        end else begin
                            // sa/sb are zero for DIVU, so no op check is needed here
                            if (sa ^ sb)
                                lo <= ~lo + 32'd1;
                            if (sa)
                                hi <= ~hi + 32'd1;
                        end
                    end else if (sa ^ sb) begin
                        {hi, lo} <= prod_neg;
                    end
                    state <= S_DONE;
                    done  <= 1'b1;
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl with a behavioural ALU model feeding alu_result/alu_carry.
module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [5:0]  alu_cont;
    logic [31:0] alu_result;
    logic        alu_carry;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign #1 {alu_carry, alu_result} = {1'b0, alu_a}
                                      + {1'b0, (alu_cont[5] ? ~alu_b : alu_b)}
                                      + {32'd0, alu_cont[5]};

    mdu_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .a          (a),
        .b          (b),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_cont   (alu_cont),
        .alu_result (alu_result),
        .alu_carry  (alu_carry),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo)
    );

    task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // lat = cycle index relative to the start cycle in which done is seen
    task automatic wait_done(output int lat);
        lat = 1;
        while (done !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (hi !== 32'd0) begin bad++; $display("FAIL reset_hi got=%h exp=0", hi); end
        total++; if (lo !== 32'd0) begin bad++; $display("FAIL reset_lo got=%h exp=0", lo); end
        total++; if (alu_cont !== 6'b000010) begin bad++; $display("FAIL reset_alu_cont got=%b exp=000010", alu_cont); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_multiply;
        int lat;
        start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL multu_busy got=%b exp=1", busy); end
        total++; if (alu_cont !== 6'b000010) begin bad++; $display("FAIL multu_alu_cont got=%b exp=000010", alu_cont); end
        total++; if (alu_b !== 32'hFFFF_FFFF) begin bad++; $display("FAIL multu_alu_b got=%h exp=ffffffff", alu_b); end
        total++; if (alu_a !== 32'd0) begin bad++; $display("FAIL multu_alu_a got=%h exp=0", alu_a); end
        wait_done(lat);
        total++; if (lat !== 34) begin bad++; $display("FAIL multu_latency got=%0d exp=34", lat); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL multu_busy_at_done got=%b exp=1", busy); end
        total++; if (hi !== 32'hFFFF_FFFE) begin bad++; $display("FAIL multu_hi got=%h exp=fffffffe", hi); end
        total++; if (lo !== 32'h0000_0001) begin bad++; $display("FAIL multu_lo got=%h exp=00000001", lo); end
        step();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL multu_done_pulse got=%b exp=0", done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL multu_busy_idle got=%b exp=0", busy); end
        total++; if (hi !== 32'hFFFF_FFFE) begin bad++; $display("FAIL multu_hi_hold got=%h exp=fffffffe", hi); end

        start_op(2'b00, 32'hFFFF_FFFD, 32'd7);
        wait_done(lat);
        total++; if (lat !== 34) begin bad++; $display("FAIL mult_neg_latency got=%0d exp=34", lat); end
        total++; if (hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mult_neg_hi got=%h exp=ffffffff", hi); end
        total++; if (lo !== 32'hFFFF_FFEB) begin bad++; $display("FAIL mult_neg_lo got=%h exp=ffffffeb", lo); end
        step();

        start_op(2'b00, 32'hFFFF_FFFD, 32'hFFFF_FFF9);
        wait_done(lat);
        total++; if (hi !== 32'd0) begin bad++; $display("FAIL mult_negneg_hi got=%h exp=0", hi); end
        total++; if (lo !== 32'd21) begin bad++; $display("FAIL mult_negneg_lo got=%h exp=15", lo); end
        step();
    endtask

    task automatic test_divide;
        int lat;
        start_op(2'b11, 32'd100, 32'd7);
        total++; if (alu_cont !== 6'b100010) begin bad++; $display("FAIL divu_alu_cont got=%b exp=100010", alu_cont); end
        total++; if (alu_b !== 32'd7) begin bad++; $display("FAIL divu_alu_b got=%h exp=7", alu_b); end
        wait_done(lat);
        total++; if (lat !== 34) begin bad++; $display("FAIL divu_latency got=%0d exp=34", lat); end
        total++; if (lo !== 32'd14) begin bad++; $display("FAIL divu_lo got=%h exp=e", lo); end
        total++; if (hi !== 32'd2) begin bad++; $display("FAIL divu_hi got=%h exp=2", hi); end
        step();
        total++; if (alu_cont !== 6'b000010) begin bad++; $display("FAIL idle_alu_cont got=%b exp=000010", alu_cont); end
        total++; if (alu_b !== 32'd0) begin bad++; $display("FAIL idle_alu_b got=%h exp=0", alu_b); end

        start_op(2'b10, 32'hFFFF_FFF9, 32'd2);
        wait_done(lat);
        total++; if (lo !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_negnum_lo got=%h exp=fffffffd", lo); end
        total++; if (hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_negnum_hi got=%h exp=ffffffff", hi); end
        step();

        start_op(2'b10, 32'd7, 32'hFFFF_FFFE);
        wait_done(lat);
        total++; if (lo !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_negden_lo got=%h exp=fffffffd", lo); end
        total++; if (hi !== 32'd1) begin bad++; $display("FAIL div_negden_hi got=%h exp=1", hi); end
        step();
    endtask

    task automatic test_div_edge;
        int lat;
        start_op(2'b11, 32'h1234_5678, 32'd0);
        wait_done(lat);
        total++; if (lat !== 34) begin bad++; $display("FAIL divzero_latency got=%0d exp=34", lat); end
        total++; if (lo !== 32'hFFFF_FFFF) begin bad++; $display("FAIL divuzero_lo got=%h exp=ffffffff", lo); end
        total++; if (hi !== 32'h1234_5678) begin bad++; $display("FAIL divuzero_hi got=%h exp=12345678", hi); end
        step();

        start_op(2'b10, 32'hFFFF_FFFB, 32'd0);
        wait_done(lat);
        total++; if (lo !== 32'hFFFF_FFFF) begin bad++; $display("FAIL divzero_lo got=%h exp=ffffffff", lo); end
        total++; if (hi !== 32'hFFFF_FFFB) begin bad++; $display("FAIL divzero_hi got=%h exp=fffffffb", hi); end
        step();

        start_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(lat);
        total++; if (lo !== 32'h8000_0000) begin bad++; $display("FAIL div_ovf_lo got=%h exp=80000000", lo); end
        total++; if (hi !== 32'd0) begin bad++; $display("FAIL div_ovf_hi got=%h exp=0", hi); end
        step();
    endtask

    task automatic test_reset_midop;
        int lat;
        int pulses;
        start_op(2'b01, 32'd5, 32'h0F0F_0F0F);
        repeat (8) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        step();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL midrst_done got=%b exp=0", done); end
        total++; if (hi !== 32'd0) begin bad++; $display("FAIL midrst_hi got=%h exp=0", hi); end
        total++; if (lo !== 32'd0) begin bad++; $display("FAIL midrst_lo got=%h exp=0", lo); end
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done === 1'b1 || busy === 1'b1) pulses++;
        end
        total++; if (pulses !== 0) begin bad++; $display("FAIL midrst_ghost_activity got=%0d exp=0", pulses); end

        start_op(2'b11, 32'd9, 32'd3);
        wait_done(lat);
        total++; if (lat !== 34) begin bad++; $display("FAIL postrst_latency got=%0d exp=34", lat); end
        total++; if (lo !== 32'd3) begin bad++; $display("FAIL postrst_lo got=%h exp=3", lo); end
        total++; if (hi !== 32'd0) begin bad++; $display("FAIL postrst_hi got=%h exp=0", hi); end
        step();
    endtask

    task automatic test_back_to_back;
        int lat;
        start_op(2'b01, 32'd5, 32'd6);
        start = 1'b1;
        lat = 1;
        while (done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            op = lat[1:0];
            a  = 32'd1000 + lat;
            b  = 32'd77 ^ lat;
            @(posedge clk);
            #1;
            lat++;
        end
        total++; if (lat !== 34) begin bad++; $display("FAIL b2b_first_latency got=%0d exp=34", lat); end
        total++; if (lo !== 32'd30) begin bad++; $display("FAIL b2b_first_lo got=%h exp=1e", lo); end
        total++; if (hi !== 32'd0) begin bad++; $display("FAIL b2b_first_hi got=%h exp=0", hi); end
        @(negedge clk);
        op = 2'b11;
        a  = 32'd50;
        b  = 32'd5;
        step();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle_busy got=%b exp=0", busy); end
        total++; if (lo !== 32'd30) begin bad++; $display("FAIL b2b_idle_lo_hold got=%h exp=1e", lo); end
        step();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_second_accept got=%b exp=1", busy); end
        start = 1'b0;
        wait_done(lat);
        total++; if (lat !== 34) begin bad++; $display("FAIL b2b_second_latency got=%0d exp=34", lat); end
        total++; if (lo !== 32'd10) begin bad++; $display("FAIL b2b_second_lo got=%h exp=a", lo); end
        total++; if (hi !== 32'd0) begin bad++; $display("FAIL b2b_second_hi got=%h exp=0", hi); end
        step();
    endtask

    initial begin
        test_reset();
        test_multiply();
        test_divide();
        test_div_edge();
        test_reset_midop();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
